// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : modexp_ctrl
// Description : Constant-time right-to-left square-and-multiply modular
//               exponentiation controller sharing one 2W-by-W reduction unit.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_MUL  = 3'd2,
        S_SQR  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_e;
    logic [WIDTH-1:0]   r_n;
    logic [c_idx_w-1:0] r_i;
    logic               r_zero_pend;

    logic [2*WIDTH-1:0] w_r_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_dividend;
    logic [WIDTH-1:0]   w_red;

    // Restoring long division; the partial remainder stays below the divisor,
    // so one conditional subtract per dividend bit is exact for any operands.
    function automatic logic [WIDTH-1:0] f_reduce(
        input logic [2*WIDTH-1:0] num,
        input logic [WIDTH-1:0]   den
    );
        logic [WIDTH:0] rem;
        rem = '0;
        for (int k = 2*WIDTH-1; k >= 0; k--) begin
            rem = {rem[WIDTH-1:0], num[k]};
            if (rem >= {1'b0, den}) begin
                rem = rem - {1'b0, den};
            end
        end
        return rem[WIDTH-1:0];
    endfunction

    assign w_r_ext = {{WIDTH{1'b0}}, r_r};
    assign w_b_ext = {{WIDTH{1'b0}}, r_b};

    always_comb begin
        w_dividend = w_b_ext;
        case (r_state)
            S_MUL:   w_dividend = w_r_ext * w_b_ext;
            S_SQR:   w_dividend = w_b_ext * w_b_ext;
            default: w_dividend = w_b_ext;
        endcase
    end

    assign w_red = f_reduce(w_dividend, r_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_b         <= '0;
            r_r         <= '0;
            r_e         <= '0;
            r_n         <= '0;
            r_i         <= '0;
            r_zero_pend <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A zero modulus completes with error one cycle after accept.
                    if (r_zero_pend) begin
                        done        <= 1'b1;
                        error       <= 1'b1;
                        result      <= '0;
                        r_zero_pend <= 1'b0;
                    end
                    if (start) begin
                        r_b <= base;
                        r_e <= exponent;
                        r_n <= modulus;
                        if (modulus != '0) begin
                            busy    <= 1'b1;
                            r_state <= S_INIT;
                        end else begin
                            r_zero_pend <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    r_b     <= w_red;
                    r_r     <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
                    r_i     <= '0;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    if (r_e[r_i]) begin
                        r_r <= w_red;
                    end
                    r_state <= S_SQR;
                end
                S_SQR: begin
                    r_b <= w_red;
                    if (r_i == c_last_idx) begin
                        r_state <= S_FIN;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_FIN: begin
                    result  <= r_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_modexp_ctrl
// Description : Self-checking bench for modexp_ctrl: vector table, corner
//               sequences and random operands against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    modexp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b;
        logic [15:0] e;
        logic [15:0] m;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Left-to-right exponentiation with plain integer arithmetic.
    function automatic logic [15:0] ref_modexp(input logic [15:0] b, input logic [15:0] e,
                                               input logic [15:0] m);
        longint unsigned acc;
        longint unsigned mm;
        longint unsigned bb;
        if (m == 16'd0) return 16'd0;
        mm  = longint'(m);
        bb  = longint'(b) % mm;
        acc = 1 % mm;
        for (int k = 15; k >= 0; k--) begin
            acc = (acc * acc) % mm;
            if (e[k]) acc = (acc * bb) % mm;
        end
        return acc[15:0];
    endfunction

    // Called #1 after the accept edge; returns completion data and latency.
    task automatic wait_done(output logic [15:0] res, output logic er,
                             output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles");
        end
        res = result;
        er  = error;
    endtask

    task automatic do_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                         output logic [15:0] res, output logic er,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(res, er, lat, busy_cnt);
    endtask

    initial begin
        logic [15:0] res;
        logic        er;
        int          lat;
        int          bcnt;
        int          ndone;
        int          first;
        logic [15:0] res_at_done;
        logic [15:0] rb, re, rm;

        vecs[0] = '{16'd4,   16'd13, 16'd497,   16'd445, 1'b0};
        vecs[1] = '{16'd100, 16'd3,  16'd7,     16'd1,   1'b0};
        vecs[2] = '{16'd9,   16'd0,  16'd7,     16'd1,   1'b0};
        vecs[3] = '{16'd5,   16'd3,  16'd1,     16'd0,   1'b0};
        vecs[4] = '{16'd0,   16'd0,  16'd11,    16'd1,   1'b0};
        vecs[5] = '{16'd0,   16'd5,  16'd13,    16'd0,   1'b0};
        vecs[6] = '{16'd2,   16'd16, 16'd65535, 16'd1,   1'b0};
        vecs[7] = '{16'd7,   16'd0,  16'd1,     16'd0,   1'b0};
        vecs[8] = '{16'd3,   16'd4,  16'd0,     16'd0,   1'b1};

        rst_n = 1'b0; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_error",  {31'd0, error}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            do_op(vecs[v].b, vecs[v].e, vecs[v].m, res, er, lat, bcnt);
            check($sformatf("vec%0d_result", v), {16'd0, res}, {16'd0, vecs[v].res});
            check($sformatf("vec%0d_error", v), {31'd0, er}, {31'd0, vecs[v].err});
            check($sformatf("vec%0d_latency", v), lat, vecs[v].err ? 32'd1 : 32'd34);
            check($sformatf("vec%0d_busy_cycles", v), bcnt, vecs[v].err ? 32'd0 : 32'd34);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_one_cycle", v), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_error_one_cycle", v), {31'd0, error}, 32'd0);
            check($sformatf("vec%0d_result_hold", v), {16'd0, result}, {16'd0, vecs[v].res});
        end

        // Back-to-back: new start accepted in the done cycle.
        do_op(16'd100, 16'd3, 16'd7, res, er, lat, bcnt);
        check("b2b_first_result", {16'd0, res}, 32'd1);
        base = 16'd2; exponent = 16'd10; modulus = 16'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(res, er, lat, bcnt);
        check("b2b_second_result", {16'd0, res}, 32'd24);
        check("b2b_second_latency", lat, 32'd34);

        // Start held high with operands changing while busy.
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        base = 16'hBEEF; exponent = 16'h1234; modulus = 16'hFFFF;
        ndone = 0; first = -1; res_at_done = '0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    res_at_done = result;
                end
            end
        end
        start = 1'b0;
        check("hold_done_count", ndone, 32'd1);
        check("hold_done_cycle", first, 32'd34);
        check("hold_result", {16'd0, res_at_done}, 32'd445);
        @(posedge clk); #1;
        check("hold_idle_after", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",   {31'd0, busy},  32'd0);
        check("rst_mid_done",   {31'd0, done},  32'd0);
        check("rst_mid_error",  {31'd0, error}, 32'd0);
        check("rst_mid_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("rst_no_done", ndone, 32'd0);
        do_op(16'd2, 16'd10, 16'd1000, res, er, lat, bcnt);
        check("rst_fresh_result", {16'd0, res}, 32'd24);
        check("rst_fresh_latency", lat, 32'd34);

        // Random operands against the reference model.
        for (int t = 0; t < 24; t++) begin
            rb = 16'($urandom);
            re = 16'($urandom);
            case (t % 6)
                0:       rm = 16'hFFFF;
                1:       rm = 16'd1;
                2:       rm = 16'($urandom_range(2, 255));
                default: rm = 16'($urandom_range(1, 65535));
            endcase
            if (t == 5) rm = 16'd0;
            do_op(rb, re, rm, res, er, lat, bcnt);
            check($sformatf("rand%0d_result b=%0d e=%0d m=%0d", t, rb, re, rm),
                  {16'd0, res}, {16'd0, ref_modexp(rb, re, rm)});
            check($sformatf("rand%0d_error", t), {31'd0, er}, (rm == 16'd0) ? 32'd1 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
